// File: rtl/fcw_glide_bank.sv
// fcw_glide_bank: programmable FCW store feeding the NCO phase accumulator.
// A select either jumps straight to the chosen entry, or glides linearly to it
// (portamento) in 2^s equal steps with a programmable hold time per step. The
// last step always snaps exactly onto the target, so floor-rounded steps never
// leave a residual error.
// MAX_SHIFT is expected to stay at 15 or below, because glide_shift is 4 bits.
module fcw_glide_bank #(
  parameter int                     WIDTH     = 24,
  parameter int                     DEPTH     = 8,
  parameter int                     AW        = $clog2(DEPTH),
  parameter logic [DEPTH*WIDTH-1:0] INIT      = '0,
  parameter int                     MAX_SHIFT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             sel_valid,
  input  logic [AW-1:0]    sel_addr,
  input  logic             glide_en,
  input  logic [3:0]       glide_shift,
  input  logic [15:0]      glide_div,
  output logic [WIDTH-1:0] fcw_out,
  output logic [AW-1:0]    cur_addr,
  output logic             busy
);

  // steps_left has to hold 2^MAX_SHIFT, so it needs one bit more than the exponent
  localparam int SLW = MAX_SHIFT + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GLIDE = 1'b1
  } state_t;

  logic [WIDTH-1:0]      mem [DEPTH];

  state_t                state;
  state_t                state_nxt;
  logic [WIDTH-1:0]      fcw_nxt;
  logic [AW-1:0]         cur_addr_nxt;
  logic                  busy_nxt;

  logic [WIDTH-1:0]      target;
  logic [WIDTH-1:0]      target_nxt;
  logic signed [WIDTH:0] step;
  logic signed [WIDTH:0] step_nxt;
  logic [SLW-1:0]        steps_left;
  logic [SLW-1:0]        steps_left_nxt;
  logic [15:0]           div_cnt;
  logic [15:0]           div_cnt_nxt;
  logic [15:0]           div_reload;
  logic [15:0]           div_reload_nxt;

  logic [3:0]            shift_eff;
  logic [WIDTH-1:0]      sel_target;
  logic signed [WIDTH:0] sel_delta;
  logic signed [WIDTH:0] sel_step;

  // Register-file storage: writes land on the edge, and reset reloads the INIT image
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= INIT[i*WIDTH +: WIDTH];
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Select-side arithmetic: clamp the exponent, read the target asynchronously, and
  // derive the floor-rounded per-step increment from the present output value
  always_comb begin
    if ({28'd0, glide_shift} > 32'(MAX_SHIFT)) begin
      shift_eff = 4'(MAX_SHIFT);
    end else begin
      shift_eff = glide_shift;
    end
    sel_target = mem[sel_addr];
    sel_delta  = $signed({1'b0, sel_target}) - $signed({1'b0, fcw_out});
    sel_step   = sel_delta >>> shift_eff;
  end

  // State and output registers; reset wins over any select or glide in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      fcw_out    <= INIT[0 +: WIDTH];
      cur_addr   <= '0;
      busy       <= 1'b0;
      target     <= '0;
      step       <= '0;
      steps_left <= '0;
      div_cnt    <= '0;
      div_reload <= '0;
    end else begin
      state      <= state_nxt;
      fcw_out    <= fcw_nxt;
      cur_addr   <= cur_addr_nxt;
      busy       <= busy_nxt;
      target     <= target_nxt;
      step       <= step_nxt;
      steps_left <= steps_left_nxt;
      div_cnt    <= div_cnt_nxt;
      div_reload <= div_reload_nxt;
    end
  end

  // Next-state logic: a select restarts from the present output in any state; while
  // gliding, each step is held for div_reload+1 cycles and the final step snaps
  always_comb begin
    state_nxt      = state;
    fcw_nxt        = fcw_out;
    cur_addr_nxt   = cur_addr;
    target_nxt     = target;
    step_nxt       = step;
    steps_left_nxt = steps_left;
    div_cnt_nxt    = div_cnt;
    div_reload_nxt = div_reload;

    if (sel_valid) begin
      target_nxt   = sel_target;
      cur_addr_nxt = sel_addr;
      if (!glide_en || (shift_eff == 4'd0)) begin
        fcw_nxt   = sel_target;
        state_nxt = IDLE;
      end else begin
        step_nxt       = sel_step;
        steps_left_nxt = SLW'(1) << shift_eff;
        div_cnt_nxt    = glide_div;
        div_reload_nxt = glide_div;
        state_nxt      = GLIDE;
      end
    end else begin
      case (state)
        IDLE: begin
          state_nxt = IDLE;
        end
        GLIDE: begin
          if (div_cnt != 16'd0) begin
            div_cnt_nxt = div_cnt - 16'd1;
          end else begin
            div_cnt_nxt = div_reload;
            if (steps_left == SLW'(1)) begin
              fcw_nxt   = target;
              state_nxt = IDLE;
            end else begin
              fcw_nxt        = WIDTH'({1'b0, fcw_out} + step);
              steps_left_nxt = steps_left - SLW'(1);
            end
          end
        end
      endcase
    end

    busy_nxt = (state_nxt == GLIDE);
  end

endmodule

// File: tb/tb_fcw_glide_bank.sv
// tb_fcw_glide_bank: directed walk through jumps, glides, retargets and hazards,
// then a randomized run, all compared edge by edge against a closed-form model.
module tb_fcw_glide_bank;

  localparam int WIDTH     = 24;
  localparam int DEPTH     = 8;
  localparam int AW        = 3;
  localparam int MAX_SHIFT = 8;
  localparam logic [DEPTH*WIDTH-1:0] INIT = {96'd0, 24'd40, 24'd30, 24'd20, 24'd10};

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             sel_valid = 1'b0;
  logic [AW-1:0]    sel_addr = '0;
  logic             glide_en = 1'b0;
  logic [3:0]       glide_shift = '0;
  logic [15:0]      glide_div = '0;
  logic [WIDTH-1:0] fcw_out;
  logic [AW-1:0]    cur_addr;
  logic             busy;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  // Reference model: the glide is described by its start, step and elapsed edges,
  // and the output is computed directly from those values
  logic [WIDTH-1:0] m_mem [DEPTH];
  logic [WIDTH-1:0] m_fcw;
  logic [AW-1:0]    m_cur;
  bit               m_glide;
  logic [WIDTH-1:0] m_tgt;
  longint           m_start;
  longint           m_step;
  int               m_k;
  int               m_s;
  int               m_div;

  fcw_glide_bank #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .INIT(INIT), .MAX_SHIFT(MAX_SHIFT)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sel_valid(sel_valid), .sel_addr(sel_addr), .glide_en(glide_en),
    .glide_shift(glide_shift), .glide_div(glide_div),
    .fcw_out(fcw_out), .cur_addr(cur_addr), .busy(busy)
  );

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  function automatic longint floor_div(input longint d, input longint q);
    if (d >= 0) return d / q;
    return -((-d + q - 1) / q);
  endfunction

  // Advance the model by one clock edge using the inputs the DUT sampled
  task automatic model_edge();
    int               s;
    longint           n;
    logic [WIDTH-1:0] tgt;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = INIT[i*WIDTH +: WIDTH];
      m_fcw   = INIT[0 +: WIDTH];
      m_cur   = '0;
      m_glide = 0;
    end else begin
      if (sel_valid) begin
        s     = (int'(glide_shift) > MAX_SHIFT) ? MAX_SHIFT : int'(glide_shift);
        tgt   = m_mem[sel_addr];
        m_cur = sel_addr;
        if (!glide_en || s == 0) begin
          m_fcw   = tgt;
          m_glide = 0;
        end else begin
          m_step  = floor_div(longint'(tgt) - longint'(m_fcw), longint'(1) << s);
          m_start = longint'(m_fcw);
          m_tgt   = tgt;
          m_s     = s;
          m_div   = int'(glide_div);
          m_k     = 0;
          m_glide = 1;
        end
      end else if (m_glide) begin
        m_k = m_k + 1;
        n   = longint'(m_k / (m_div + 1));
        if (n >= (longint'(1) << m_s)) begin
          m_fcw   = m_tgt;
          m_glide = 0;
        end else begin
          m_fcw = WIDTH'(m_start + n * m_step);
        end
      end
      if (wr_en) m_mem[wr_addr] = wr_data;
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_output(input string tag);
    check_val({tag, ".fcw"}, 32'(fcw_out), 32'(m_fcw));
    check_val({tag, ".busy"}, 32'(busy), 32'(m_glide));
    check_val({tag, ".cur"}, 32'(cur_addr), 32'(m_cur));
  endtask

  // One clock edge: DUT and model both take the current inputs, then pulses drop
  task automatic apply_stimulus();
    @(posedge clk);
    model_edge();
    #1;
    wr_en     = 1'b0;
    sel_valid = 1'b0;
    rst       = 1'b0;
  endtask

  task automatic do_write(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = WIDTH'(d);
  endtask

  task automatic do_select(input int a, input bit ge, input int sh, input int dv);
    sel_valid   = 1'b1;
    sel_addr    = AW'(a);
    glide_en    = ge;
    glide_shift = 4'(sh);
    glide_div   = 16'(dv);
  endtask

  initial begin
    int down_exp[4];
    down_exp = '{1750, 1500, 1250, 1003};

    // Reset image
    rst = 1'b1; apply_stimulus();
    rst = 1'b1; apply_stimulus();
    check_output("reset");
    check_val("reset.fcw_init0", 32'(fcw_out), 10);

    // Plain jumps to the INIT entries
    for (int a = 1; a < 4; a++) begin
      do_select(a, 0, 0, 0); apply_stimulus();
      check_output("jump");
      check_val("jump.value", 32'(fcw_out), 32'(10 * (a + 1)));
    end

    // Write, then jump on the next cycle
    do_write(5, 1000); apply_stimulus();
    check_output("wr5");
    do_select(5, 0, 0, 0); apply_stimulus();
    check_output("jump5");
    check_val("jump5.value", 32'(fcw_out), 1000);
    check_val("jump5.busy", 32'(busy), 0);

    // Upward glide 1000 -> 2000, four steps, each held two cycles
    do_write(2, 2000); apply_stimulus();
    do_select(2, 1, 2, 1); apply_stimulus();
    check_output("up.e0");
    check_val("up.busy_rise", 32'(busy), 1);
    for (int e = 1; e <= 8; e++) begin
      apply_stimulus();
      check_output("up");
      if (e % 2 == 0) check_val("up.value", 32'(fcw_out), 32'(1000 + 125 * e));
    end
    check_val("up.busy_fall", 32'(busy), 0);

    // Downward glide that does not divide evenly, so the last step snaps
    do_write(3, 1003); apply_stimulus();
    do_select(3, 1, 2, 0); apply_stimulus();
    check_output("down.e0");
    for (int e = 1; e <= 4; e++) begin
      apply_stimulus();
      check_output("down");
      check_val("down.value", 32'(fcw_out), 32'(down_exp[e-1]));
    end

    // Retarget while a glide is in progress
    do_write(6, 4096); apply_stimulus();
    do_write(7, 512);  apply_stimulus();
    do_select(4, 0, 0, 0); apply_stimulus();
    check_val("retarget.zero", 32'(fcw_out), 0);
    do_select(6, 1, 3, 0); apply_stimulus();
    for (int e = 1; e <= 3; e++) begin
      apply_stimulus();
      check_output("retarget.first");
    end
    check_val("retarget.mid", 32'(fcw_out), 1536);
    do_select(7, 1, 1, 0); apply_stimulus();
    check_output("retarget.sel");
    apply_stimulus();
    check_output("retarget.r1");
    check_val("retarget.r1_value", 32'(fcw_out), 1024);
    apply_stimulus();
    check_output("retarget.r2");
    check_val("retarget.r2_value", 32'(fcw_out), 512);
    check_val("retarget.busy", 32'(busy), 0);

    // Overwrite the glide target mid-glide; the glide keeps the old target
    do_select(6, 1, 2, 0); apply_stimulus();
    apply_stimulus();
    do_write(6, 9999); apply_stimulus();
    check_output("wrglide.mid");
    apply_stimulus();
    apply_stimulus();
    check_output("wrglide.end");
    check_val("wrglide.value", 32'(fcw_out), 4096);
    do_select(6, 0, 0, 0); apply_stimulus();
    check_val("wrglide.newdata", 32'(fcw_out), 9999);

    // Write and select of the same entry on the same edge
    do_write(1, 777); do_select(1, 0, 0, 0); apply_stimulus();
    check_output("collide.sel");
    check_val("collide.old", 32'(fcw_out), 20);
    do_select(1, 0, 0, 0); apply_stimulus();
    check_val("collide.new", 32'(fcw_out), 777);

    // Oversized shift clamps to MAX_SHIFT; the step is zero and only the snap moves
    do_select(5, 1, 12, 0); apply_stimulus();
    for (int e = 1; e <= 255; e++) begin
      apply_stimulus();
      check_output("clamp");
    end
    check_val("clamp.busy255", 32'(busy), 1);
    apply_stimulus();
    check_output("clamp.end");
    check_val("clamp.value", 32'(fcw_out), 1000);
    check_val("clamp.busy256", 32'(busy), 0);

    // Reset in the middle of a glide
    do_select(6, 1, 3, 1); apply_stimulus();
    apply_stimulus();
    apply_stimulus();
    check_output("rstglide.pre");
    rst = 1'b1; apply_stimulus();
    check_output("rstglide");
    check_val("rstglide.fcw", 32'(fcw_out), 10);
    check_val("rstglide.busy", 32'(busy), 0);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      if ($urandom % 4 == 0) do_write(int'($urandom_range(0, DEPTH - 1)), int'($urandom & 32'hFFFFFF));
      if ($urandom % 8 == 0)
        do_select(int'($urandom_range(0, DEPTH - 1)), ($urandom % 4) != 0,
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
      if ($urandom % 300 == 0) rst = 1'b1;
      apply_stimulus();
      check_output("rand");
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
